pipe_if_stage: RTL and testbench
================================

PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 pcsource  input  2  next-PC select from decode: 00 pc+4, 01 bpc, 10 rpc, 11 jpc.
REQ-004 bpc  input  32  branch target from ID.
REQ-005 rpc  input  32  register (jr) target from ID.
REQ-006 jpc  input  32  jump target from ID.
REQ-007 wpcir  input  1  1 = PC and IF/ID may advance; 0 = load-use stall, hold.
REQ-008 jwait  input  1  1 = ID holds a taken jump/branch; redirect and squash fetch.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  32  word-aligned fetch address.
REQ-011 imem_ack  input  1  read data valid this cycle; ignored while imem_req=0.
REQ-012 imem_rdata  input  32  fetched instruction.
REQ-013 pc  output  32  current fetch PC.
REQ-014 dinst  output  32  IF/ID instruction to decode (op=dinst[31:26], func=dinst[5:0]).
REQ-015 dpc4  output  32  IF/ID PC+4 of dinst.
REQ-016 dvalid  output  1  dinst is a real instruction (0 = bubble).

Function
REQ-017 States: FETCH (request outstanding), HOLD (fetched word buffered during stall), DRAIN (discarding stale in-flight fetch after redirect).
REQ-018 imem_req SHALL be 1 in FETCH and DRAIN, 0 in HOLD; imem_addr SHALL equal pc and stay stable while imem_req=1 and imem_ack=0.
REQ-019 redirect = jwait & wpcir; target = mux(pcsource); pc+4 computed modulo 2^32, wrap from 0xFFFFFFFC to 0.
REQ-020 FETCH, ack, wpcir, ~jwait: dinst<=imem_rdata, dpc4<=pc+4, dvalid<=1, pc<=pc+4; stay FETCH.
REQ-021 FETCH, ack, ~wpcir: word into hold buffer, IF/ID and pc unchanged; go HOLD.
REQ-022 FETCH, ~ack, wpcir, ~jwait: dinst<=0 (NOP), dvalid<=0, pc unchanged; stay FETCH.
REQ-023 FETCH, ~wpcir, ~ack: all state unchanged.
REQ-024 FETCH, redirect, ack same cycle: word dropped, pc<=target, dinst<=0, dvalid<=0; stay FETCH.
REQ-025 FETCH, redirect, ~ack: pc<=target, dinst<=0, dvalid<=0; go DRAIN.
REQ-026 DRAIN: next ack discarded, go FETCH (new request at target next cycle); further redirect in DRAIN updates pc, stays DRAIN.
REQ-027 HOLD, ~wpcir: unchanged. HOLD, wpcir, ~jwait: dinst<=buffer, dpc4<=pc+4, dvalid<=1, pc<=pc+4, go FETCH. HOLD, redirect: buffer dropped, pc<=target, dinst<=0, dvalid<=0, go FETCH.
REQ-028 jwait with wpcir=0 SHALL be ignored (stall has priority; decode re-presents it).
REQ-029 Exactly one instruction enters IF/ID per accepted ack; none duplicated or lost except on redirect.

Reset
REQ-030 reset SHALL force pc=0, dinst=0, dpc4=0, dvalid=0, hold buffer=0, state=FETCH, imem_req=0 during the reset cycle.
REQ-031 First cycle after reset deasserts: imem_req=1, imem_addr=0.
REQ-032 Reset mid-fetch or in DRAIN/HOLD SHALL abandon the transaction; an ack arriving in the reset cycle is ignored.

Structure
REQ-033 Shared package: state encoding, NOP=32'h0, pcsource codes (PCS_SEQ/BR/JR/J), RESET_PC=32'h0.
REQ-034 One sub-module pipe_npc_mux: combinational 4:1 next-PC select plus pc+4 adder.

Verification
REQ-035 Reset, zero-latency ack, wpcir=1, jwait=0, 4 cycles -> dinst sequences mem[0..3], dpc4 4,8,12,16, pc=0x10.
REQ-036 2-cycle ack latency at pc=0x20 -> one bubble (dinst=0, dvalid=0), then dinst=mem[0x20], dpc4=0x24.
REQ-037 Ack with wpcir=0 for 3 cycles -> HOLD, imem_req=0, dinst unchanged; wpcir=1 -> dinst=buffered word, pc+=4.
REQ-038 jwait=1, pcsource=11, jpc=0x400, fetch pending -> DRAIN, dvalid=0; stale ack dropped; next imem_addr=0x400.
REQ-039 jwait=1, pcsource=10, rpc=0x80, with simultaneous ack -> word dropped, pc=0x80, no DRAIN.
REQ-040 pc=0xFFFFFFFC fetched -> pc wraps to 0, dpc4=0.

Source files
------------

// File: rtl/pipe_if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package pipe_if_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_DRAIN = 2'b10
  } if_state_e;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JR  = 2'b10;
  localparam logic [1:0] PCS_J   = 2'b11;

endpackage

// File: rtl/pipe_npc_mux.sv
// Next-PC selection: sequential pc+4 (wrapping at 2^32) or one of the decode targets.
module pipe_npc_mux
  import pipe_if_stage_pkg::*;
(
  input  logic [1:0]  pcsource_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] bpc_i,
  input  logic [31:0] rpc_i,
  input  logic [31:0] jpc_i,
  output logic [31:0] pc4_o,
  output logic [31:0] target_o
);

  assign pc4_o = pc_i + 32'd4;

  always_comb begin
    target_o = pc4_o;
    case (pcsource_i)
      PCS_SEQ: target_o = pc4_o;
      PCS_BR:  target_o = bpc_i;
      PCS_JR:  target_o = rpc_i;
      PCS_J:   target_o = jpc_i;
      default: target_o = pc4_o;
    endcase
  end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC register, memory handshake, stall buffer and IF/ID register.
module pipe_if_stage
  import pipe_if_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        wpcir,
  input  logic        jwait,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dinst,
  output logic [31:0] dpc4,
  output logic        dvalid
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dinst_q, dinst_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic        dvalid_q, dvalid_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pc4, target;
  logic        redirect;

  pipe_npc_mux u_npc_mux (
    .pcsource_i (pcsource),
    .pc_i       (pc_q),
    .bpc_i      (bpc),
    .rpc_i      (rpc),
    .jpc_i      (jpc),
    .pc4_o      (pc4),
    .target_o   (target)
  );

  // A stall (wpcir=0) outranks a pending jump; decode re-presents it later.
  assign redirect = jwait & wpcir;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    dinst_d  = dinst_q;
    dpc4_d   = dpc4_q;
    dvalid_d = dvalid_q;
    buf_d    = buf_q;
    case (state_q)
      ST_FETCH: begin
        if (!wpcir) begin
          if (imem_ack) begin
            buf_d   = imem_rdata;
            state_d = ST_HOLD;
          end
        end else if (jwait) begin
          pc_d     = target;
          dinst_d  = NOP;
          dvalid_d = 1'b0;
          if (!imem_ack) state_d = ST_DRAIN;
        end else if (imem_ack) begin
          dinst_d  = imem_rdata;
          dpc4_d   = pc4;
          dvalid_d = 1'b1;
          pc_d     = pc4;
        end else begin
          dinst_d  = NOP;
          dvalid_d = 1'b0;
        end
      end
      // The in-flight word belongs to the abandoned path; swallow exactly one ack.
      ST_DRAIN: begin
        if (redirect) begin
          pc_d     = target;
          dinst_d  = NOP;
          dvalid_d = 1'b0;
        end else if (imem_ack) begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (wpcir) begin
          state_d = ST_FETCH;
          if (jwait) begin
            pc_d     = target;
            dinst_d  = NOP;
            dvalid_d = 1'b0;
          end else begin
            dinst_d  = buf_q;
            dpc4_d   = pc4;
            dvalid_d = 1'b1;
            pc_d     = pc4;
          end
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      dinst_q  <= NOP;
      dpc4_q   <= 32'h0;
      dvalid_q <= 1'b0;
      buf_q    <= NOP;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      dinst_q  <= dinst_d;
      dpc4_q   <= dpc4_d;
      dvalid_q <= dvalid_d;
      buf_q    <= buf_d;
    end
  end

  assign imem_req  = ~reset & (state_q != ST_HOLD);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign dinst     = dinst_q;
  assign dpc4      = dpc4_q;
  assign dvalid    = dvalid_q;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Bench for pipe_if_stage: directed vector table, hand sequences, randomized run vs. a reference model.
module tb_pipe_if_stage;

  logic        clk;
  logic        reset;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        wpcir, jwait;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] dut_pc, dut_dinst, dut_dpc4;
  logic        dut_dvalid;

  int total = 0;
  int bad   = 0;

  pipe_if_stage dut (
    .clock      (clk),
    .reset      (reset),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .wpcir      (wpcir),
    .jwait      (jwait),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (dut_pc),
    .dinst      (dut_dinst),
    .dpc4       (dut_dpc4),
    .dvalid     (dut_dvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mw(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Reference model: fetch unit seen as "buffered word present" and "stale ack to skip".
  logic [31:0] m_pc, m_dinst, m_dpc4, m_buf;
  logic        m_dvalid, m_have_buf, m_skip;

  // Samples of the DUT taken during the last cycle.
  logic        s_req;
  logic [31:0] s_addr, s_pc, s_dinst, s_dpc4;
  logic        s_dvalid;
  logic        e_req;
  logic [31:0] e_addr;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] sel_target(input logic [1:0] s);
    case (s)
      2'd1:    return bpc;
      2'd2:    return rpc;
      2'd3:    return jpc;
      default: return m_pc + 32'd4;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] tgt;
    tgt = sel_target(pcsource);
    if (reset) begin
      m_pc = 0; m_dinst = 0; m_dpc4 = 0; m_dvalid = 0;
      m_buf = 0; m_have_buf = 0; m_skip = 0;
    end else if (m_skip) begin
      if (jwait && wpcir) begin
        m_pc = tgt; m_dinst = 0; m_dvalid = 0;
      end else if (imem_ack) m_skip = 0;
    end else if (m_have_buf) begin
      if (wpcir) begin
        m_have_buf = 0;
        if (jwait) begin
          m_pc = tgt; m_dinst = 0; m_dvalid = 0;
        end else begin
          m_dinst = m_buf; m_dpc4 = m_pc + 32'd4; m_dvalid = 1; m_pc = m_pc + 32'd4;
        end
      end
    end else if (!wpcir) begin
      if (imem_ack) begin m_buf = imem_rdata; m_have_buf = 1; end
    end else if (jwait) begin
      m_pc = tgt; m_dinst = 0; m_dvalid = 0;
      if (!imem_ack) m_skip = 1;
    end else if (imem_ack) begin
      m_dinst = imem_rdata; m_dpc4 = m_pc + 32'd4; m_dvalid = 1; m_pc = m_pc + 32'd4;
    end else begin
      m_dinst = 0; m_dvalid = 0;
    end
  endtask

  // One clock: drive after the falling edge, sample before and after the rising edge.
  task automatic do_cycle(input logic rst, input logic wp, input logic jw,
                          input logic [1:0] pcs, input logic ack);
    @(negedge clk);
    reset = rst; wpcir = wp; jwait = jw; pcsource = pcs; imem_ack = ack;
    imem_rdata = ack ? mw(m_pc) : $urandom;
    e_req  = !rst && !m_have_buf;
    e_addr = m_pc;
    #1;
    s_req = imem_req; s_addr = imem_addr;
    @(posedge clk);
    model_step();
    #1;
    s_pc = dut_pc; s_dinst = dut_dinst; s_dpc4 = dut_dpc4; s_dvalid = dut_dvalid;
    $display("cyc rst=%0b wp=%0b jw=%0b pcs=%0d ack=%0b req=%0b addr=%h pc=%h dinst=%h dpc4=%h dv=%0b",
             rst, wp, jw, pcs, ack, s_req, s_addr, s_pc, s_dinst, s_dpc4, s_dvalid);
  endtask

  task automatic chk_model(input int idx);
    chk("req", idx, {31'b0, s_req}, {31'b0, e_req});
    if (e_req) chk("addr", idx, s_addr, e_addr);
    chk("pc", idx, s_pc, m_pc);
    chk("dinst", idx, s_dinst, m_dinst);
    chk("dpc4", idx, s_dpc4, m_dpc4);
    chk("dvalid", idx, {31'b0, s_dvalid}, {31'b0, m_dvalid});
  endtask

  typedef struct {
    logic        rst, wp, jw;
    logic [1:0]  pcs;
    logic        ack;
    logic        req;
    logic [31:0] addr, pc, dinst, dpc4;
    logic        dv;
  } vec_t;

  vec_t vecs[32];
  int   nv = 0;

  task automatic addv(input logic rst, input logic wp, input logic jw, input logic [1:0] pcs,
                      input logic ack, input logic req, input logic [31:0] addr,
                      input logic [31:0] pcv, input logic [31:0] di, input logic [31:0] d4,
                      input logic dv);
    vecs[nv] = '{rst, wp, jw, pcs, ack, req, addr, pcv, di, d4, dv};
    nv++;
  endtask

  initial begin
    reset = 1; wpcir = 1; jwait = 0; pcsource = 0; imem_ack = 0; imem_rdata = 0;
    bpc = 32'h200; rpc = 32'h80; jpc = 32'h400;
    m_pc = 0; m_dinst = 0; m_dpc4 = 0; m_dvalid = 0; m_buf = 0; m_have_buf = 0; m_skip = 0;

    //   rst wp jw pcs ack | req addr        | pc          dinst          dpc4        dv
    addv(1, 1, 0, 0, 1,  0, 32'h0,   32'h0,   32'h0,      32'h0,   0); // ack in reset ignored
    addv(0, 1, 0, 0, 1,  1, 32'h0,   32'h4,   mw(32'h0),  32'h4,   1);
    addv(0, 1, 0, 0, 1,  1, 32'h4,   32'h8,   mw(32'h4),  32'h8,   1);
    addv(0, 1, 0, 0, 1,  1, 32'h8,   32'hC,   mw(32'h8),  32'hC,   1);
    addv(0, 1, 0, 0, 1,  1, 32'hC,   32'h10,  mw(32'hC),  32'h10,  1);
    addv(0, 1, 0, 0, 1,  1, 32'h10,  32'h14,  mw(32'h10), 32'h14,  1);
    addv(0, 1, 0, 0, 1,  1, 32'h14,  32'h18,  mw(32'h14), 32'h18,  1);
    addv(0, 1, 0, 0, 1,  1, 32'h18,  32'h1C,  mw(32'h18), 32'h1C,  1);
    addv(0, 1, 0, 0, 1,  1, 32'h1C,  32'h20,  mw(32'h1C), 32'h20,  1);
    addv(0, 1, 0, 0, 0,  1, 32'h20,  32'h20,  32'h0,      32'h20,  0); // latency bubble
    addv(0, 1, 0, 0, 1,  1, 32'h20,  32'h24,  mw(32'h20), 32'h24,  1);
    addv(0, 0, 0, 0, 1,  1, 32'h24,  32'h24,  mw(32'h20), 32'h24,  1); // into HOLD
    addv(0, 0, 0, 0, 0,  0, 32'h24,  32'h24,  mw(32'h20), 32'h24,  1);
    addv(0, 0, 0, 0, 0,  0, 32'h24,  32'h24,  mw(32'h20), 32'h24,  1);
    addv(0, 1, 0, 0, 0,  0, 32'h24,  32'h28,  mw(32'h24), 32'h28,  1); // release buffer
    addv(0, 1, 1, 3, 0,  1, 32'h28,  32'h400, 32'h0,      32'h28,  0); // jump, fetch pending
    addv(0, 1, 0, 0, 1,  1, 32'h400, 32'h400, 32'h0,      32'h28,  0); // stale ack dropped
    addv(0, 1, 0, 0, 1,  1, 32'h400, 32'h404, mw(32'h400),32'h404, 1);
    addv(0, 1, 1, 2, 1,  1, 32'h404, 32'h80,  32'h0,      32'h404, 0); // jr with ack
    addv(0, 1, 0, 0, 1,  1, 32'h80,  32'h84,  mw(32'h80), 32'h84,  1);
    addv(0, 0, 1, 3, 0,  1, 32'h84,  32'h84,  mw(32'h80), 32'h84,  1); // jwait under stall ignored
    addv(0, 1, 0, 0, 1,  1, 32'h84,  32'h88,  mw(32'h84), 32'h88,  1);
    addv(0, 0, 0, 0, 1,  1, 32'h88,  32'h88,  mw(32'h84), 32'h88,  1); // HOLD
    addv(1, 1, 0, 0, 0,  0, 32'h0,   32'h0,   32'h0,      32'h0,   0); // reset abandons HOLD
    addv(0, 1, 0, 0, 1,  1, 32'h0,   32'h4,   mw(32'h0),  32'h4,   1);

    for (int i = 0; i < nv; i++) begin
      do_cycle(vecs[i].rst, vecs[i].wp, vecs[i].jw, vecs[i].pcs, vecs[i].ack);
      chk("t_req", i, {31'b0, s_req}, {31'b0, vecs[i].req});
      if (vecs[i].req) chk("t_addr", i, s_addr, vecs[i].addr);
      chk("t_pc", i, s_pc, vecs[i].pc);
      chk("t_dinst", i, s_dinst, vecs[i].dinst);
      chk("t_dpc4", i, s_dpc4, vecs[i].dpc4);
      chk("t_dvalid", i, {31'b0, s_dvalid}, {31'b0, vecs[i].dv});
    end

    // Redirect taken while a word sits in the hold buffer.
    bpc = 32'h300;
    do_cycle(1, 1, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 1);
    do_cycle(0, 1, 1, 1, 0);
    chk("hold_redir_req", 100, {31'b0, s_req}, 32'h0);
    chk("hold_redir_pc", 100, s_pc, 32'h300);
    chk("hold_redir_dv", 100, {31'b0, s_dvalid}, 32'h0);
    do_cycle(0, 1, 0, 0, 1);
    chk("hold_redir_addr", 101, s_addr, 32'h300);
    chk("hold_redir_dinst", 101, s_dinst, mw(32'h300));

    // PC wrap at the top of the address space.
    jpc = 32'hFFFF_FFFC;
    do_cycle(0, 1, 1, 3, 1);
    chk("wrap_pc0", 110, s_pc, 32'hFFFF_FFFC);
    do_cycle(0, 1, 0, 0, 1);
    chk("wrap_addr", 111, s_addr, 32'hFFFF_FFFC);
    chk("wrap_pc", 111, s_pc, 32'h0);
    chk("wrap_dpc4", 111, s_dpc4, 32'h0);
    chk("wrap_dinst", 111, s_dinst, mw(32'hFFFF_FFFC));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      bpc = $urandom & 32'hFFFF_FFFC;
      rpc = $urandom & 32'hFFFF_FFFC;
      jpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      do_cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      chk_model(200 + i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
